// File: rtl/drbg_ctrl_if.sv
// rtl/drbg_ctrl_if.sv - host request handshake between the requester and the DRBG controller.
interface drbg_ctrl_if;
   logic        req_valid_i;
   logic [15:0] req_blocks_i;
   logic        force_reseed_i;
   logic        req_ready_o;
   logic        req_done_o;

   modport master (
      output req_valid_i,
      output req_blocks_i,
      output force_reseed_i,
      input  req_ready_o,
      input  req_done_o
   );

   modport slave (
      input  req_valid_i,
      input  req_blocks_i,
      input  force_reseed_i,
      output req_ready_o,
      output req_done_o
   );
endinterface

// File: rtl/drbg_ctrl.sv
// rtl/drbg_ctrl.sv - DRBG sequencer: instantiate, periodic/forced reseed, generate, timeout watchdog.
// Command pulses are combinational from state and busy_i so they fire on the cycle busy_i drops.
module drbg_ctrl #(
   parameter int RESEED_INTERVAL = 511,
   parameter int TIMEOUT_CYCLES  = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   drbg_ctrl_if.slave  host,
   output logic        instantiate_o,
   output logic        reseed_o,
   output logic        generate_o,
   output logic [15:0] num_blocks_o,
   input  logic        busy_i,
   input  logic        done_i,
   output logic        instantiated_o,
   output logic [15:0] gen_count_o,
   output logic        err_o
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   typedef logic [TW-1:0] tmo_t;
   localparam logic [15:0] RESEED_LIM = 16'(RESEED_INTERVAL);
   localparam tmo_t        TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
   localparam tmo_t        TMO_START  = TW'(1);

   typedef enum logic [3:0] {
      INIT,
      ISSUE_INST,
      WAIT_INST,
      IDLE,
      ISSUE_RESEED,
      WAIT_RESEED,
      ISSUE_GEN,
      WAIT_GEN,
      ERROR
   } state_t;

   state_t      state_q, state_d;
   tmo_t        tmo_q, tmo_d;
   logic [15:0] gen_cnt_q, gen_cnt_d;
   logic [15:0] blocks_q, blocks_d;
   logic        inst_q, inst_d;
   logic        err_q, err_d;
   logic        zdone_q, zdone_d;
   logic        ready_c;
   logic        gen_done_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= INIT;
         tmo_q     <= '0;
         gen_cnt_q <= '0;
         blocks_q  <= '0;
         inst_q    <= 1'b0;
         err_q     <= 1'b0;
         zdone_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmo_q     <= tmo_d;
         gen_cnt_q <= gen_cnt_d;
         blocks_q  <= blocks_d;
         inst_q    <= inst_d;
         err_q     <= err_d;
         zdone_q   <= zdone_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      tmo_d         = tmo_q;
      gen_cnt_d     = gen_cnt_q;
      blocks_d      = blocks_q;
      inst_d        = inst_q;
      err_d         = err_q;
      zdone_d       = 1'b0;
      ready_c       = 1'b0;
      gen_done_c    = 1'b0;
      instantiate_o = 1'b0;
      reseed_o      = 1'b0;
      generate_o    = 1'b0;

      case (state_q)
         INIT: state_d = ISSUE_INST;

         ISSUE_INST: begin
            if (!busy_i) begin
               instantiate_o = 1'b1;
               tmo_d         = TMO_START;
               state_d       = WAIT_INST;
            end
         end

         ISSUE_RESEED: begin
            if (!busy_i) begin
               reseed_o = 1'b1;
               tmo_d    = TMO_START;
               state_d  = WAIT_RESEED;
            end
         end

         ISSUE_GEN: begin
            if (!busy_i) begin
               generate_o = 1'b1;
               tmo_d      = TMO_START;
               state_d    = WAIT_GEN;
            end
         end

         IDLE: begin
            ready_c = inst_q && !err_q && !host.force_reseed_i && (gen_cnt_q < RESEED_LIM);
            // Reseeding outranks a request arriving in the same cycle.
            if (host.force_reseed_i || (gen_cnt_q >= RESEED_LIM)) begin
               state_d = ISSUE_RESEED;
            end else if (host.req_valid_i && ready_c) begin
               blocks_d = host.req_blocks_i;
               if (host.req_blocks_i == 16'd0) begin
                  zdone_d = 1'b1;
               end else begin
                  state_d = ISSUE_GEN;
               end
            end
         end

         WAIT_INST, WAIT_RESEED, WAIT_GEN: begin
            // done_i wins over a timeout expiring in the same cycle.
            if (done_i) begin
               state_d = IDLE;
               if (state_q == WAIT_GEN) begin
                  gen_done_c = 1'b1;
                  if (gen_cnt_q != 16'hFFFF) begin
                     gen_cnt_d = gen_cnt_q + 16'd1;
                  end
               end else begin
                  gen_cnt_d = '0;
                  inst_d    = 1'b1;
               end
            end else if (tmo_q == TMO_LAST) begin
               state_d = ERROR;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end

         ERROR: err_d = 1'b1;

         default: state_d = INIT;
      endcase
   end

   assign host.req_ready_o = ready_c;
   assign host.req_done_o  = gen_done_c | zdone_q;
   assign num_blocks_o     = blocks_q;
   assign instantiated_o   = inst_q;
   assign gen_count_o      = gen_cnt_q;
   assign err_o            = err_q;

endmodule

// File: tb/tb_drbg_ctrl.sv
// tb/tb_drbg_ctrl.sv - directed bench for drbg_ctrl with short reseed interval and timeout.
module tb_drbg_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        busy_i;
   logic        done_i;
   logic        instantiate_o;
   logic        reseed_o;
   logic        generate_o;
   logic [15:0] num_blocks_o;
   logic        instantiated_o;
   logic [15:0] gen_count_o;
   logic        err_o;

   int n_chk  = 0;
   int n_fail = 0;
   int cmd_pulses = 0;
   int gen_pulses = 0;
   int snap_gen;
   int snap_cmd;

   drbg_ctrl_if host_if ();

   drbg_ctrl #(
      .RESEED_INTERVAL(2),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .host          (host_if.slave),
      .instantiate_o (instantiate_o),
      .reseed_o      (reseed_o),
      .generate_o    (generate_o),
      .num_blocks_o  (num_blocks_o),
      .busy_i        (busy_i),
      .done_i        (done_i),
      .instantiated_o(instantiated_o),
      .gen_count_o   (gen_count_o),
      .err_o         (err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      #2;
      if (rst_n === 1'b1) begin
         n_chk++;
         assert ((int'(instantiate_o) + int'(reseed_o) + int'(generate_o)) <= 1) else begin
            n_fail++;
            $error("FAIL onehot_cmd: observed %b%b%b expected at most one", instantiate_o, reseed_o, generate_o);
         end
         cmd_pulses += int'(instantiate_o) + int'(reseed_o) + int'(generate_o);
         gen_pulses += int'(generate_o);
      end
   end

   initial begin
      rst_n = 1'b0; busy_i = 1'b0; done_i = 1'b0;
      host_if.req_valid_i = 1'b0; host_if.req_blocks_i = 16'd0; host_if.force_reseed_i = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_inst", instantiate_o, 0);
      chk("rst_ready", host_if.req_ready_o, 0);
      chk("rst_gencnt", gen_count_o, 0);
      chk("rst_nblk", num_blocks_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_instd", instantiated_o, 0);

      // Instantiation after reset release
      @(negedge clk); rst_n = 1'b1; #1;
      chk("inst_cycle1", instantiate_o, 0);
      @(negedge clk); #1;
      chk("inst_pulse", instantiate_o, 1);
      chk("inst_no_reseed", reseed_o, 0);
      chk("inst_no_gen", generate_o, 0);
      @(negedge clk); #1;
      chk("inst_once", instantiate_o, 0);
      repeat (9) @(negedge clk);
      done_i = 1'b1; #1;
      chk("inst_done_ready", host_if.req_ready_o, 0);
      chk("inst_done_noreq", host_if.req_done_o, 0);
      @(negedge clk); done_i = 1'b0; #1;
      chk("instd_set", instantiated_o, 1);
      chk("ready_after_inst", host_if.req_ready_o, 1);
      chk("gencnt_after_inst", gen_count_o, 0);

      // Request 1: 4 blocks
      host_if.req_valid_i = 1'b1; host_if.req_blocks_i = 16'd4; #1;
      chk("r1_ready", host_if.req_ready_o, 1);
      @(negedge clk); host_if.req_valid_i = 1'b0; #1;
      chk("r1_gen", generate_o, 1);
      chk("r1_nblk", num_blocks_o, 4);
      @(negedge clk); #1;
      chk("r1_gen_once", generate_o, 0);
      chk("r1_nblk_hold", num_blocks_o, 4);
      @(negedge clk); done_i = 1'b1; #1;
      chk("r1_done", host_if.req_done_o, 1);
      @(negedge clk); done_i = 1'b0; #1;
      chk("r1_done_1cyc", host_if.req_done_o, 0);
      chk("r1_gencnt", gen_count_o, 1);

      // Request 2: 5 blocks reaches the reseed interval
      host_if.req_valid_i = 1'b1; host_if.req_blocks_i = 16'd5;
      @(negedge clk); host_if.req_valid_i = 1'b0; #1;
      chk("r2_gen", generate_o, 1);
      chk("r2_nblk", num_blocks_o, 5);
      @(negedge clk); done_i = 1'b1; #1;
      chk("r2_done", host_if.req_done_o, 1);
      @(negedge clk); done_i = 1'b0; #1;
      chk("r2_gencnt", gen_count_o, 2);
      chk("r3_held", host_if.req_ready_o, 0);
      host_if.req_valid_i = 1'b1; host_if.req_blocks_i = 16'd6;
      @(negedge clk); #1;
      chk("auto_reseed", reseed_o, 1);
      chk("auto_reseed_nogen", generate_o, 0);
      @(negedge clk); #1;
      chk("auto_reseed_once", reseed_o, 0);
      @(negedge clk); done_i = 1'b1; #1;
      @(negedge clk); done_i = 1'b0; #1;
      chk("reseed_clr_cnt", gen_count_o, 0);
      chk("r3_ready", host_if.req_ready_o, 1);
      @(negedge clk); host_if.req_valid_i = 1'b0; #1;
      chk("r3_gen", generate_o, 1);
      chk("r3_nblk", num_blocks_o, 6);
      @(negedge clk); done_i = 1'b1;
      @(negedge clk); done_i = 1'b0; #1;
      chk("r3_gencnt", gen_count_o, 1);

      // Forced reseed with a simultaneous request
      host_if.force_reseed_i = 1'b1; host_if.req_valid_i = 1'b1; host_if.req_blocks_i = 16'd3; #1;
      chk("force_ready", host_if.req_ready_o, 0);
      @(negedge clk); host_if.force_reseed_i = 1'b0; #1;
      chk("force_reseed", reseed_o, 1);
      chk("force_nogen", generate_o, 0);
      @(negedge clk); #1;
      chk("force_wait_ready", host_if.req_ready_o, 0);
      @(negedge clk);
      @(negedge clk); done_i = 1'b1; #1;
      chk("force_done_nogen", generate_o, 0);
      @(negedge clk); done_i = 1'b0; #1;
      chk("force_gencnt", gen_count_o, 0);
      chk("force_ready_after", host_if.req_ready_o, 1);
      @(negedge clk); host_if.req_valid_i = 1'b0; #1;
      chk("force_gen", generate_o, 1);
      chk("force_nblk", num_blocks_o, 3);
      @(negedge clk); done_i = 1'b1; #1;
      chk("force_req_done", host_if.req_done_o, 1);
      @(negedge clk); done_i = 1'b0; #1;
      chk("force_gencnt2", gen_count_o, 1);

      // Zero-block request
      snap_gen = gen_pulses;
      host_if.req_valid_i = 1'b1; host_if.req_blocks_i = 16'd0; #1;
      chk("zero_ready", host_if.req_ready_o, 1);
      @(negedge clk); host_if.req_valid_i = 1'b0; #1;
      chk("zero_done", host_if.req_done_o, 1);
      chk("zero_nogen", generate_o, 0);
      chk("zero_idle", host_if.req_ready_o, 1);
      @(negedge clk); #1;
      chk("zero_done_1cyc", host_if.req_done_o, 0);
      chk("zero_gencnt", gen_count_o, 1);
      chk("zero_gen_pulses", gen_pulses, snap_gen);

      // Generate held off by busy_i for 5 cycles
      host_if.req_valid_i = 1'b1; host_if.req_blocks_i = 16'd7; busy_i = 1'b1;
      @(negedge clk); host_if.req_valid_i = 1'b0; #1;
      chk("busy_gen_c1", generate_o, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         chk("busy_gen_hold", generate_o, 0);
      end
      @(negedge clk); busy_i = 1'b0; #1;
      chk("busy_fall_gen", generate_o, 1);
      chk("busy_nblk", num_blocks_o, 7);
      @(negedge clk); #1;
      chk("busy_gen_once", generate_o, 0);
      @(negedge clk); done_i = 1'b1; #1;
      chk("busy_req_done", host_if.req_done_o, 1);
      @(negedge clk); done_i = 1'b0; #1;
      chk("busy_gencnt", gen_count_o, 2);

      // Reset in the middle of a reseed
      @(negedge clk); #1;
      chk("mid_reseed", reseed_o, 1);
      @(negedge clk); #1;
      rst_n = 1'b0; #1;
      chk("mid_rst_gencnt", gen_count_o, 0);
      chk("mid_rst_instd", instantiated_o, 0);
      chk("mid_rst_nblk", num_blocks_o, 0);
      chk("mid_rst_ready", host_if.req_ready_o, 0);
      @(negedge clk); host_if.req_valid_i = 1'b1; host_if.req_blocks_i = 16'd2; rst_n = 1'b1; #1;
      chk("reinst_ready0", host_if.req_ready_o, 0);
      @(negedge clk); #1;
      chk("reinst_pulse", instantiate_o, 1);
      chk("reinst_nogen", generate_o, 0);
      chk("reinst_ready1", host_if.req_ready_o, 0);
      repeat (3) @(negedge clk);
      done_i = 1'b1;
      @(negedge clk); done_i = 1'b0; #1;
      chk("reinst_instd", instantiated_o, 1);
      chk("reinst_ready", host_if.req_ready_o, 1);

      // Timeout: done_i withheld after generate
      @(negedge clk); host_if.req_valid_i = 1'b0; #1;
      chk("tmo_gen", generate_o, 1);
      chk("tmo_nblk", num_blocks_o, 2);
      repeat (15) @(negedge clk);
      #1;
      chk("tmo_err_c15", err_o, 0);
      @(negedge clk); #1;
      chk("tmo_err_c16", err_o, 1);
      chk("tmo_ready", host_if.req_ready_o, 0);
      snap_cmd = cmd_pulses;
      host_if.req_valid_i = 1'b1; host_if.force_reseed_i = 1'b1; done_i = 1'b1;
      @(negedge clk); done_i = 1'b0; host_if.force_reseed_i = 1'b0;
      repeat (5) @(negedge clk);
      #3;
      chk("err_sticky", err_o, 1);
      chk("err_ready", host_if.req_ready_o, 0);
      chk("err_no_cmds", cmd_pulses, snap_cmd);
      chk("err_no_done", host_if.req_done_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
